// File: rtl/led_pwm_fader.sv
// Per-channel PWM fader: each of 4 LEDs ramps its brightness toward the target bit.
// Optional macro LED_FADE_GAMMA_EN selects a square-law duty curve (default: linear).
module led_pwm_fader #(
    parameter int PWM_BITS = 8,
    parameter int STEP_DIV = 48_828
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] led_in,
    output logic [3:0] led_out
);

    localparam int                  PRESC_W   = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PRESC_W-1:0]  PRESC_MAX = PRESC_W'(STEP_DIV - 1);
    localparam logic [PWM_BITS-1:0] LEVEL_MAX = '1;

    logic [3:0]                tgt_q;
    logic [PRESC_W-1:0]        presc_q;
    logic [PRESC_W-1:0]        presc_d;
    logic [PWM_BITS-1:0]       pwm_cnt_q;
    logic [3:0][PWM_BITS-1:0]  level_q;
    logic [3:0][PWM_BITS-1:0]  level_d;
    logic [3:0][PWM_BITS-1:0]  duty;
    logic [3:0]                led_d;
    logic                      tick;

    always_comb begin
        tick    = (presc_q == PRESC_MAX);
        presc_d = tick ? '0 : presc_q + 1'b1;
        level_d = level_q;
        duty    = '0;
        led_d   = '0;
        for (int i = 0; i < 4; i++) begin
            // Levels saturate at both ends; a target flip simply reverses the next step.
            if (tick) begin
                if (tgt_q[i] && (level_q[i] != LEVEL_MAX)) begin
                    level_d[i] = level_q[i] + 1'b1;
                end else if (!tgt_q[i] && (level_q[i] != '0)) begin
                    level_d[i] = level_q[i] - 1'b1;
                end
            end
`ifdef LED_FADE_GAMMA_EN
            duty[i] = PWM_BITS'(((2*PWM_BITS)'(level_q[i]) * (2*PWM_BITS)'(level_q[i])) >> PWM_BITS);
`else
            duty[i] = level_q[i];
`endif
            // Full level forces constant on so there is no single-cycle dropout per period.
            led_d[i] = (level_q[i] == LEVEL_MAX) ? 1'b1 : (duty[i] > pwm_cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tgt_q     <= '0;
            presc_q   <= '0;
            pwm_cnt_q <= '0;
            level_q   <= '0;
            led_out   <= '0;
        end else begin
            tgt_q     <= led_in;
            presc_q   <= presc_d;
            pwm_cnt_q <= pwm_cnt_q + 1'b1;
            level_q   <= level_d;
            led_out   <= led_d;
        end
    end

endmodule

// File: tb/tb_led_pwm_fader.sv
// Directed bench for led_pwm_fader: reset, full ramp, reversal, cross-fade, mid-ramp reset, duty.
// Duty expectation follows LED_FADE_GAMMA_EN when that macro is defined for the build.
module tb_led_pwm_fader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rst2_n;
    logic [3:0] led_in;
    logic [3:0] led_in2;
    logic [3:0] led_out;
    logic [3:0] led_out2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    led_pwm_fader #(.PWM_BITS(8), .STEP_DIV(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .led_in  (led_in),
        .led_out (led_out)
    );

    // Prescaler period equals the PWM period, so the level is frozen across one whole PWM window.
    led_pwm_fader #(.PWM_BITS(8), .STEP_DIV(256)) dut2 (
        .clk     (clk),
        .rst_n   (rst2_n),
        .led_in  (led_in2),
        .led_out (led_out2)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] pattern, input int cycles);
        led_in = pattern;
        repeat (cycles) @(negedge clk);
    endtask

    initial begin
        int cnt;
        int sum;
        int dutyExp;

        rst_n   = 1'b0;
        rst2_n  = 1'b0;
        led_in  = 4'b1111;
        led_in2 = 4'b0001;

        applyStimulus(4'b1111, 3);
        checkOutput("rst_led_out", {28'd0, led_out}, 32'h0);
        checkOutput("rst_levels", dut.level_q, 32'h0);

        rst_n = 1'b1;
        applyStimulus(4'b1111, 1);
        checkOutput("ramp_e1", dut.level_q, 32'h0);
        applyStimulus(4'b1111, 1);
        checkOutput("ramp_first_tick", dut.level_q, 32'h01010101);
        applyStimulus(4'b1111, 507);
        checkOutput("ramp_254", dut.level_q, 32'hFEFEFEFE);
        applyStimulus(4'b1111, 1);
        checkOutput("ramp_255", dut.level_q, 32'hFFFFFFFF);
        applyStimulus(4'b1111, 1);
        checkOutput("full_on_out", {28'd0, led_out}, 32'hF);
        cnt = 0;
        for (int i = 0; i < 256; i++) begin
            applyStimulus(4'b1111, 1);
            if (led_out == 4'b1111) cnt++;
        end
        checkOutput("full_on_constant", cnt, 256);
        checkOutput("saturate_high", dut.level_q, 32'hFFFFFFFF);

        rst_n = 1'b0;
        applyStimulus(4'b0001, 1);
        rst_n = 1'b1;
        checkOutput("rst2_led_out", {28'd0, led_out}, 32'h0);
        checkOutput("rst2_levels", dut.level_q, 32'h0);
        applyStimulus(4'b0001, 200);
        checkOutput("rise_100", dut.level_q, 32'h00000064);
        applyStimulus(4'b0000, 1);
        checkOutput("rev_hold", dut.level_q, 32'h00000064);
        applyStimulus(4'b0000, 1);
        checkOutput("rev_99", dut.level_q, 32'h00000063);
        applyStimulus(4'b0000, 196);
        checkOutput("rev_1", dut.level_q, 32'h00000001);
        applyStimulus(4'b0000, 2);
        checkOutput("rev_0", dut.level_q, 32'h0);
        cnt = 0;
        for (int i = 0; i < 300; i++) begin
            applyStimulus(4'b0000, 1);
            if (led_out[0]) cnt++;
        end
        checkOutput("off_constant", cnt, 0);
        checkOutput("saturate_low", dut.level_q, 32'h0);

        applyStimulus(4'b0001, 510);
        checkOutput("xfade_start", dut.level_q, 32'h000000FF);
        applyStimulus(4'b0010, 1);
        checkOutput("xfade_first", dut.level_q, 32'h000000FF);
        for (int i = 0; i < 510; i++) begin
            applyStimulus(4'b0010, 1);
            sum = int'(dut.level_q[0]) + int'(dut.level_q[1]);
            checkOutput("xfade_sum", sum, 255);
        end
        checkOutput("xfade_end", dut.level_q, 32'h0000FF00);

        applyStimulus(4'b0100, 361);
        checkOutput("mid_180", dut.level_q, 32'h00B44B00);
        rst_n = 1'b0;
        applyStimulus(4'b0100, 1);
        rst_n = 1'b1;
        checkOutput("mid_rst_levels", dut.level_q, 32'h0);
        checkOutput("mid_rst_led_out", {28'd0, led_out}, 32'h0);
        applyStimulus(4'b0100, 2);
        checkOutput("restart_1", dut.level_q, 32'h00010000);

`ifdef LED_FADE_GAMMA_EN
        dutyExp = 64;
`else
        dutyExp = 128;
`endif
        rst2_n = 1'b1;
        applyStimulus(4'b0100, 32768);
        checkOutput("duty_level", dut2.level_q, 32'h00000080);
        cnt = 0;
        for (int i = 0; i < 256; i++) begin
            applyStimulus(4'b0100, 1);
            if (i == 0) checkOutput("duty_first", {31'd0, led_out2[0]}, 32'h1);
            if (i == 255) checkOutput("duty_last", {31'd0, led_out2[0]}, 32'h0);
            if (led_out2[0]) cnt++;
        end
        checkOutput("duty_count", cnt, dutyExp);
        checkOutput("duty_others", {29'd0, led_out2[3:1]}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
